reg_file_mp: RTL and testbench

Parametrised multi-port register file for the CPU datapath: configurable data width, depth and read-port count, two write ports with a defined priority, asynchronous clear, and a per-register pending scoreboard that tracks outstanding producers. Sits between decode (reads, scoreboard marks) and write-back (two retiring results per cycle). Register 0 is hard-wired to zero.

---
 rtl/reg_file_mp_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 50 +++++
 rtl/reg_file_mp.sv | 90 +++++++++
 tb/tb_reg_file_mp.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and packed-port slice helper for the multi-port register file.
package reg_file_mp_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_NUM_RD     = 2;

    // Low bit of port `port` within a packed bus of `width`-bit fields.
    function automatic int unsigned port_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-producer scoreboard: one bit per register, mark beats write-back clear,
// entry 0 held at zero, with one lookup output per read port.
module rf_scoreboard
    import reg_file_mp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_RD     = DEF_NUM_RD
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wen0,
    input  logic [ADDR_WIDTH-1:0]        waddr0,
    input  logic                         wen1,
    input  logic [ADDR_WIDTH-1:0]        waddr1,
    input  logic                         mark_en,
    input  logic [ADDR_WIDTH-1:0]        mark_addr,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD-1:0]            rbusy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_next;

    // Later assignments take priority: clears first, then the mark.
    always_comb begin
        pending_next = pending;
        if (wen0)
            pending_next[waddr0] = 1'b0;
        if (wen1)
            pending_next[waddr1] = 1'b0;
        if (mark_en)
            pending_next[mark_addr] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= '0;
        else
            pending <= pending_next;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_lookup
        localparam int unsigned ALO = port_lo(i, ADDR_WIDTH);
        assign rbusy[i] = pending[raddr[ALO +: ADDR_WIDTH]];
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD async read ports,
// r0 hard-wired to zero. Define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_RD     = DEF_NUM_RD
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wen0,
    input  logic [ADDR_WIDTH-1:0]        waddr0,
    input  logic [DATA_WIDTH-1:0]        wdata0,
    input  logic                         wen1,
    input  logic [ADDR_WIDTH-1:0]        waddr1,
    input  logic [DATA_WIDTH-1:0]        wdata1,
    input  logic                         mark_en,
    input  logic [ADDR_WIDTH-1:0]        mark_addr,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [NUM_RD-1:0]     sb_busy;

    // Port 1 is written second so it wins an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < DEPTH; r++)
                mem[ADDR_WIDTH'(r)] <= '0;
        end else begin
            if (wen0 && waddr0 != '0)
                mem[waddr0] <= wdata0;
            if (wen1 && waddr1 != '0)
                mem[waddr1] <= wdata1;
        end
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RD     (NUM_RD)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .wen0      (wen0),
        .waddr0    (waddr0),
        .wen1      (wen1),
        .waddr1    (waddr1),
        .mark_en   (mark_en),
        .mark_addr (mark_addr),
        .raddr     (raddr),
        .rbusy     (sb_busy)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        localparam int unsigned ALO = port_lo(i, ADDR_WIDTH);
        localparam int unsigned DLO = port_lo(i, DATA_WIDTH);

        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;
        logic                  rb;

        assign ra = raddr[ALO +: ADDR_WIDTH];

        always_comb begin
            rd = (ra == '0) ? '0 : mem[ra];
            rb = sb_busy[i];
`ifdef RF_BYPASS_EN
            // Forwarding is suppressed while reset holds the file cleared.
            if (!rst && ra != '0) begin
                if (wen1 && waddr1 == ra) begin
                    rd = wdata1;
                    rb = mark_en && mark_addr == ra;
                end else if (wen0 && waddr0 == ra) begin
                    rd = wdata0;
                    rb = mark_en && mark_addr == ra;
                end
            end
`endif
        end

        assign rdata[DLO +: DATA_WIDTH] = rd;
        assign rbusy[i]                 = rb;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (NUM_RD=4): directed steps plus random traffic
// against an array-based reference model; follows RF_BYPASS_EN if defined.
module tb_reg_file_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              wen0, wen1, mark_en;
    logic [AW-1:0]     waddr0, waddr1, mark_addr;
    logic [DW-1:0]     wdata0, wdata1;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] m_mem  [DEPTH];
    logic          m_pend [DEPTH];

    reg_file_mp #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_RD     (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wen0      (wen0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .wen1      (wen1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .mark_en   (mark_en),
        .mark_addr (mark_addr),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < DEPTH; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge: writes land (port 1 last), then marks.
    task automatic model_edge();
        if (rst) return;
        if (wen0 && waddr0 != 0) begin m_mem[waddr0] = wdata0; m_pend[waddr0] = 1'b0; end
        if (wen1 && waddr1 != 0) begin m_mem[waddr1] = wdata1; m_pend[waddr1] = 1'b0; end
        if (mark_en && mark_addr != 0) m_pend[mark_addr] = 1'b1;
    endtask

    task automatic check_reads(input string tag);
        logic [AW-1:0] a;
        logic [DW-1:0] ed;
        logic          eb;
        for (int i = 0; i < NR; i++) begin
            a  = raddr[i*AW +: AW];
            ed = (a == 0) ? '0 : m_mem[a];
            eb = (a == 0) ? 1'b0 : m_pend[a];
`ifdef RF_BYPASS_EN
            if (!rst && a != 0 && ((wen1 && waddr1 == a) || (wen0 && waddr0 == a))) begin
                ed = (wen1 && waddr1 == a) ? wdata1 : wdata0;
                eb = mark_en && mark_addr == a;
            end
`endif
            check($sformatf("%s.rdata%0d", tag, i), rdata[i*DW +: DW], ed);
            check($sformatf("%s.rbusy%0d", tag, i), DW'(rbusy[i]), DW'(eb));
        end
    endtask

    // Called just after a falling edge: drive, check combinational reads, take the edge.
    task automatic cycle(input string tag,
                         input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic m, input logic [AW-1:0] ma, input logic [NR*AW-1:0] ra);
        wen0 = w0; waddr0 = a0; wdata0 = d0;
        wen1 = w1; waddr1 = a1; wdata1 = d1;
        mark_en = m; mark_addr = ma; raddr = ra;
        #1;
        check_reads(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic logic [NR*AW-1:0] rd4(input int a0, input int a1, input int a2, input int a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    initial begin
        rst = 1'b1;
        wen0 = 0; waddr0 = '0; wdata0 = '0;
        wen1 = 0; waddr1 = '0; wdata1 = '0;
        mark_en = 0; mark_addr = '0; raddr = rd4(5, 7, 3, 1);
        model_clear();
        @(negedge clk);
        cycle("reset_held", 1, 5, 32'h1234, 1, 7, 32'h99, 1, 3, rd4(5, 7, 3, 0));
        rst = 1'b0;

        // Asynchronous reset between edges clears r5 and its pending bit at once.
        cycle("r5_write", 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5, rd4(5, 0, 0, 0));
        cycle("r5_after", 0, 0, 0, 0, 0, 0, 0, 0, rd4(5, 5, 0, 0));
        wen0 = 1; waddr0 = 6; wdata0 = 32'hCAFEF00D; raddr = rd4(5, 6, 0, 0);
        #2 rst = 1'b1;
        model_clear();
        #1 check_reads("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle("rst_discard", 0, 0, 0, 0, 0, 0, 0, 0, rd4(5, 6, 0, 0));

        cycle("r0_write", 1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0, rd4(0, 0, 0, 0));
        cycle("r0_read", 0, 0, 0, 0, 0, 0, 0, 0, rd4(0, 1, 0, 2));

        cycle("collide", 1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 0, rd4(7, 0, 0, 0));
        cycle("collide_rd", 0, 0, 0, 0, 0, 0, 0, 0, rd4(7, 7, 0, 0));

        cycle("mark_r3", 0, 0, 0, 0, 0, 0, 1, 3, rd4(3, 0, 0, 0));
        cycle("r3_busy", 1, 3, 32'h5, 0, 0, 0, 0, 0, rd4(3, 0, 0, 0));
        cycle("r3_clear", 0, 0, 0, 0, 0, 0, 0, 0, rd4(3, 0, 0, 0));
        cycle("mark_wr_r3", 0, 0, 0, 1, 3, 32'h6, 1, 3, rd4(3, 3, 0, 0));
        cycle("r3_still", 0, 0, 0, 0, 0, 0, 0, 0, rd4(3, 0, 3, 0));

        cycle("r9_init", 1, 9, 32'h1, 0, 0, 0, 0, 0, rd4(0, 0, 0, 0));
        cycle("r9_bypass", 1, 9, 32'hABCD, 0, 0, 0, 0, 0, rd4(9, 0, 0, 0));
        cycle("r9_next", 0, 0, 0, 0, 0, 0, 0, 0, rd4(9, 0, 0, 0));

        cycle("mp_w12", 1, 1, 32'd1, 1, 2, 32'd2, 0, 0, rd4(0, 0, 0, 0));
        cycle("mp_w34", 1, 3, 32'd3, 1, 4, 32'd4, 0, 0, rd4(0, 0, 0, 0));
        cycle("mp_distinct", 0, 0, 0, 0, 0, 0, 0, 0, rd4(1, 2, 3, 4));
        cycle("mp_same", 0, 0, 0, 0, 0, 0, 0, 0, rd4(2, 2, 2, 2));

        // Narrow address range forces frequent collisions and mark/write overlaps.
        for (int n = 0; n < 400; n++) begin
            cycle("rand",
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                  rd4(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 31))));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
